// File: rtl/key_debouncer.sv
// Multi-channel key conditioner: 2-flop synchroniser, stability-counter debounce, press/release
// pulses. Define KEY_DEBOUNCER_REPEAT_EN to compile in the auto-repeat pulse generator.
module key_debouncer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [WIDTH-1:0] iKeys,
  output logic [WIDTH-1:0] oLevel,
  output logic [WIDTH-1:0] oPress,
  output logic [WIDTH-1:0] oRelease,
  output logic [WIDTH-1:0] oRepeat
);

  localparam int unsigned      CntW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IdleRaw = {WIDTH{ACTIVE_LOW}};

  if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gen_bad_cfg
    $error("key_debouncer: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q, sample;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];

  // Normalised so that 1 always means pressed.
  assign sample = sync2_q ^ IdleRaw;

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sample[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        cnt_d[i]     = '0;
        level_d[i]   = sample[i];
        press_d[i]   = sample[i];
        release_d[i] = ~sample[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      sync1_q   <= IdleRaw;
      sync2_q   <= IdleRaw;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= iKeys;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign oLevel   = level_q;
  assign oPress   = press_q;
  assign oRelease = release_q;

`ifdef KEY_DEBOUNCER_REPEAT_EN
  localparam int unsigned     RepW     = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepFirst = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepWrap  = RepW'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  logic [RepW-1:0]  rep_q [WIDTH];
  logic [RepW-1:0]  rep_d [WIDTH];
  logic [WIDTH-1:0] repeat_q, repeat_d;

  // Count only while held across the edge: press edge starts at 0, release edge clears silently.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      rep_d[i]    = '0;
      repeat_d[i] = 1'b0;
      if (level_q[i] && level_d[i]) begin
        if (rep_q[i] == RepWrap) begin
          rep_d[i]    = RepDelay;
          repeat_d[i] = 1'b1;
        end else begin
          rep_d[i]    = rep_q[i] + 1'b1;
          repeat_d[i] = (rep_q[i] == RepFirst);
        end
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      repeat_q <= '0;
      for (int i = 0; i < WIDTH; i++) rep_q[i] <= '0;
    end else begin
      repeat_q <= repeat_d;
      for (int i = 0; i < WIDTH; i++) rep_q[i] <= rep_d[i];
    end
  end

  assign oRepeat = repeat_q;
`else
  assign oRepeat = '0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: table vectors, corner sequences and a random run
// compared cycle by cycle against a window-based reference model.
module tb_key_debouncer;
  localparam int W  = 4;
  localparam int S  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic         iClock = 1'b0;
  logic         iReset;
  logic [W-1:0] iKeys;
  logic [W-1:0] oLevel, oPress, oRelease, oRepeat;

  always #5 iClock = ~iClock;

  key_debouncer #(
    .WIDTH        (W),
    .STABLE_CYCLES(S),
    .ACTIVE_LOW   (1'b1),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .iClock  (iClock),
    .iReset  (iReset),
    .iKeys   (iKeys),
    .oLevel  (oLevel),
    .oPress  (oPress),
    .oRelease(oRelease),
    .oRepeat (oRepeat)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: a sample becomes visible two edges after it is applied; a channel flips
  // when the last S samples since its previous flip all disagree with its level.
  logic [W-1:0] m_level, m_press, m_rel, m_rep;
  logic [W-1:0] rawq[$];
  logic [W-1:0] hist[$];
  int           since[W];
  int           held[W];

  function automatic void model_reset();
    m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
    rawq.delete(); rawq.push_back('0); rawq.push_back('0);
    hist.delete();
    for (int c = 0; c < W; c++) begin since[c] = 0; held[c] = 0; end
  endfunction

  function automatic void model_edge(input logic [W-1:0] pressed);
    logic [W-1:0] samp;
    bit           flip;
    samp = rawq.pop_front();
    rawq.push_back(pressed);
    hist.push_back(samp);
    if (hist.size() > S) void'(hist.pop_front());
    m_press = '0; m_rel = '0; m_rep = '0;
    for (int c = 0; c < W; c++) begin
      since[c]++;
      flip = (since[c] >= S);
      if (flip)
        for (int k = 0; k < S; k++)
          if (hist[hist.size()-1-k][c] == m_level[c]) flip = 0;
      if (flip) begin
        m_level[c] = ~m_level[c];
        m_press[c] = m_level[c];
        m_rel[c]   = ~m_level[c];
        since[c]   = 0;
      end
`ifdef KEY_DEBOUNCER_REPEAT_EN
      if (m_press[c]) held[c] = 0;
      else if (m_level[c]) begin
        held[c]++;
        if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0)) m_rep[c] = 1'b1;
      end else held[c] = 0;
`endif
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [W-1:0] keys, input bit rst);
    iKeys  = keys;
    iReset = rst;
    if (rst) model_reset();
    @(posedge iClock);
    if (rst) model_reset();
    else model_edge(~keys);
    #1;
    chk("model_level", oLevel, m_level);
    chk("model_press", oPress, m_press);
    chk("model_release", oRelease, m_rel);
    chk("model_repeat", oRepeat, m_rep);
  endtask

  typedef struct {
    logic [W-1:0] keys;
    logic [W-1:0] lvl;
    logic [W-1:0] prs;
    logic [W-1:0] rel;
  } vec_t;

  vec_t         tbl[24];
  logic [W-1:0] rk;
  int           np, nr, pat, relj;
  int           rep_at[$];

  initial begin
    // Clean press on channel 0 then a clean release; edge index i counts from the first change.
    for (int i = 0; i < 24; i++) begin
      tbl[i].keys = (i < 12) ? 4'hE : 4'hF;
      tbl[i].lvl  = {3'b000, (i >= 9 && i < 21) ? 1'b1 : 1'b0};
      tbl[i].prs  = {3'b000, (i == 9) ? 1'b1 : 1'b0};
      tbl[i].rel  = {3'b000, (i == 21) ? 1'b1 : 1'b0};
    end

    iKeys  = '1;
    iReset = 1'b1;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      tick(4'hF, 1);
      chk("reset_outputs", {oLevel, oPress, oRelease, oRepeat}, 0);
    end
    for (int i = 0; i < 20; i++) begin
      tick(4'hF, 0);
      chk("idle_outputs", {oLevel, oPress, oRelease, oRepeat}, 0);
    end

    for (int i = 0; i < 24; i++) begin
      tick(tbl[i].keys, 0);
      chk("tbl_level", oLevel, tbl[i].lvl);
      chk("tbl_press", oPress, tbl[i].prs);
      chk("tbl_release", oRelease, tbl[i].rel);
    end

    // Bounce on channel 1: runs of 3 never reach S, then a stable hold.
    np = 0;
    for (int i = 0; i < 40; i++) begin
      tick(((i / 3) % 2 == 0) ? 4'hD : 4'hF, 0);
      if (oPress[1]) np++;
    end
    chk("bounce_no_press", np, 0);
    pat = -1;
    for (int j = 0; j < 14; j++) begin
      tick(4'hD, 0);
      if (oPress[1]) begin np++; if (pat < 0) pat = j; end
    end
    chk("bounce_press_edge", pat, 9);
    chk("bounce_press_count", np, 1);
    for (int j = 0; j < 12; j++) tick(4'hF, 0);

    // Glitch on channel 0: 7 held, 1 released, then held from index 8.
    np = 0; pat = -1;
    for (int j = 0; j < 22; j++) begin
      tick((j == 7) ? 4'hF : 4'hE, 0);
      if (oPress[0]) begin np++; if (pat < 0) pat = j; end
    end
    chk("glitch_press_edge", pat, 17);
    chk("glitch_press_count", np, 1);
    for (int j = 0; j < 12; j++) tick(4'hF, 0);

    // Reset while channel 2 is held: no release, fresh press after deassertion.
    nr = 0;
    for (int j = 0; j < 13; j++) begin
      tick(4'hB, 0);
      if (oRelease[2]) nr++;
    end
    chk("hold_level2", oLevel[2], 1);
    for (int j = 0; j < 3; j++) begin
      tick(4'hB, 1);
      chk("rst_level2", oLevel[2], 0);
      if (oRelease[2]) nr++;
    end
    pat = -1;
    for (int j = 0; j < 12; j++) begin
      tick(4'hB, 0);
      if (oPress[2] && pat < 0) pat = j;
      if (oRelease[2]) nr++;
    end
    chk("rst_repress_edge", pat, 9);
    chk("rst_no_release", nr, 0);
    for (int j = 0; j < 12; j++) tick(4'hF, 0);

`ifdef KEY_DEBOUNCER_REPEAT_EN
    // Channel 3 pressed at 9; repeats at 29,34,39,44,49; release at 54 suppresses its repeat.
    relj = -1;
    for (int j = 0; j < 60; j++) begin
      tick((j < 45) ? 4'h7 : 4'hF, 0);
      if (oRepeat[3]) rep_at.push_back(j);
      if (oRelease[3] && relj < 0) relj = j;
    end
    chk("rep_release_edge", relj, 54);
    chk("rep_count", rep_at.size(), 5);
    for (int k = 0; k < rep_at.size(); k++) chk("rep_edge", rep_at[k], 29 + RP * k);
`endif

    // Random traffic with occasional resets.
    rk = '1;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(9) == 0) rk[c] = ~rk[c];
      if ($urandom_range(399) == 0) begin
        tick(rk, 1);
        tick(rk, 1);
      end
      tick(rk, 0);
      chk("press_release_exclusive", oPress & oRelease, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
